// File: rtl/demux16_pkg.sv
// Shared parameters and FSM state type for the serial-to-parallel 1:WIDTH collector.
package demux16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SEL_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/demux16_collector.sv
// Serial-to-parallel demultiplexer: one bit per handshake into an assembly register,
// completed words presented on a valid/ready output with one word of skid storage.
module demux16_collector
    import demux16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel_en,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] bit_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] asm_q, asm_d, asm_next;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] cnt_q, cnt_d, idx;
    logic             out_valid_q, out_valid_d;
    logic             acc, last, slot_free;

    assign in_ready  = rst_n && (state_q == COLLECT);
    assign acc       = in_valid && in_ready;
    assign idx       = sel_en ? sel : cnt_q;
    assign last      = (cnt_q == SEL_W'(WIDTH - 1));
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        asm_next      = asm_q;
        asm_next[idx] = in;
    end

    // The output word drops at a consuming edge unless a new word is loaded at that same edge.
    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        if (clr) begin
            asm_d   = '0;
            cnt_d   = '0;
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (acc) begin
                        cnt_d = cnt_q + 1'b1;
                        if (!last) begin
                            asm_d = asm_next;
                        end else if (slot_free) begin
                            out_d       = asm_next;
                            out_valid_d = 1'b1;
                            asm_d       = '0;
                        end else begin
                            asm_d   = asm_next;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_d       = asm_q;
                        out_valid_d = 1'b1;
                        asm_d       = '0;
                        state_d     = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            asm_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_demux16_collector.sv
// Randomised and directed bench for demux16_collector, using a word-level reference model
// (a two-entry word store) and a scoreboard of expected output words.
module tb_demux16_collector;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in;
    logic        in_valid;
    logic        in_ready;
    logic        sel_en;
    logic [3:0]  sel;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bit_cnt;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] mWord;
    int          mCnt;
    int          mStored;
    logic [15:0] expQ[$];

    demux16_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel_en    (sel_en),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        mWord   = '0;
        mCnt    = 0;
        mStored = 0;
        expQ.delete();
    endtask

    // Word-level model: up to two completed words stored (output slot plus one held word).
    task automatic modelEdge();
        bit         acc;
        bit         consume;
        logic [3:0] idx;
        if (!rst_n) return;
        acc     = in_valid && (mStored < 2);
        consume = (mStored > 0) && out_ready;
        if (clr) begin
            if (mStored == 2) begin
                if (expQ.size() > 0) void'(expQ.pop_back());
                mStored--;
            end
            mWord = '0;
            mCnt  = 0;
        end else if (acc) begin
            idx        = sel_en ? sel : 4'(mCnt);
            mWord[idx] = in;
            mCnt++;
            if (mCnt == 16) begin
                expQ.push_back(mWord);
                mStored++;
                mWord = '0;
                mCnt  = 0;
            end
        end
        if (consume) mStored--;
    endtask

    task automatic applyStimulus(input logic v, input logic b, input logic se, input logic [3:0] s,
                                 input logic c, input logic ordy);
        in_valid  = v;
        in        = b;
        sel_en    = se;
        sel       = s;
        clr       = c;
        out_ready = ordy;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic sendBits(input logic [15:0] word, input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, word[i], 1'b0, 4'd0, 1'b0, ordy);
    endtask

    always @(negedge clk) begin
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (rst_n && (mStored < 2))});
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, (mStored > 0)});
        checkOutput("bit_cnt", {28'd0, bit_cnt}, 32'(mCnt));
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL word_present actual=%0h required=none at %0t", out, $time);
            end else begin
                checkOutput("word", {16'd0, out}, {16'd0, expQ[0]});
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] w;
        rst_n     = 1'b1;
        clr       = 1'b0;
        in        = 1'b1;
        in_valid  = 1'b1;
        sel_en    = 1'b0;
        sel       = 4'd0;
        out_ready = 1'b0;
        resetModel();
        #1 rst_n = 1'b0;

        // Reset holds the block idle even with valid input.
        repeat (2) begin
            @(posedge clk);
            modelEdge();
        end
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out", {16'd0, out}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        rst_n = 1'b1;

        // Auto-index mode with free output.
        sendBits(16'h3f0a, 16, 1'b1);
        checkOutput("auto_out", {16'd0, out}, 32'h3f0a);
        checkOutput("auto_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("auto_valid_drop", {31'd0, out_valid}, 32'd0);

        // Back-pressure fills output slot then the held word.
        sendBits(16'h3f0a, 16, 1'b0);
        sendBits(16'h00ff, 16, 1'b0);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_out", {16'd0, out}, 32'h3f0a);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("bp_out2", {16'd0, out}, 32'h00ff);
        checkOutput("bp_valid2", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_in_ready2", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

        // Addressed mode with a repeated index.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hf, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hd, 1'b0, 1'b1);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1);
        checkOutput("addr_out", {16'd0, out}, 32'ha003);

        // Clear wins over a same-cycle accept.
        w = 16'($urandom);
        sendBits(16'h5555, 7, 1'b1);
        checkOutput("clr_pre_cnt", {28'd0, bit_cnt}, 32'd7);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("clr_cnt", {28'd0, bit_cnt}, 32'd0);
        checkOutput("clr_out", {16'd0, out}, 32'ha003);
        sendBits(w, 16, 1'b1);
        checkOutput("clr_new_word", {16'd0, out}, {16'd0, w});

        // Asynchronous reset in the middle of a word.
        sendBits(16'hffff, 9, 1'b1);
        checkOutput("mid_cnt", {28'd0, bit_cnt}, 32'd9);
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("async_out", {16'd0, out}, 32'd0);
        checkOutput("async_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_cnt", {28'd0, bit_cnt}, 32'd0);
        checkOutput("async_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        modelEdge();
        #1 rst_n = 1'b1;
        w = 16'($urandom);
        sendBits(w, 16, 1'b1);
        checkOutput("post_rst_word", {16'd0, w}, {16'd0, out});

        // Randomised traffic against the model and scoreboard.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                          4'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0));
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
